// File: rtl/sklansky_addsub_pipe.sv
// Two-stage pipelined add/sub/absdiff/accumulate unit built on a Sklansky prefix adder.
// Optional unsigned saturation is enabled by defining SKLANSKY_SAT_EN.
module sklansky_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ABS = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  // Handshake: a transfer happens on any edge where valid && ready are both high.
  // in_ready depends only on pipeline state, never on in_valid.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_x, s1_y;
  logic             s1_cin, s1_clr, s1_swap;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] acc_q;

  logic s2_adv, s1_adv, accept;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Carry-in is folded into bit 0's generate so the tree yields every carry directly.
  function automatic logic [WIDTH:0] prefix_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic cin);
    logic [WIDTH-1:0] p, gp, pp, gn, pn, carry;
    int j;
    p     = x ^ y;
    gp    = x & y;
    gp[0] = gp[0] | (p[0] & cin);
    pp    = p;
    for (int l = 0; l < LEVELS; l++) begin
      gn = gp;
      pn = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          j     = ((i >> l) << l) - 1;
          gn[i] = gp[i] | (pp[i] & gp[j]);
          pn[i] = pp[i] & pp[j];
        end
      end
      gp = gn;
      pp = pn;
    end
    carry = {gp[WIDTH-2:0], cin};
    return {gp[WIDTH-1], p ^ carry};
  endfunction

  logic [WIDTH-1:0] c_x, c_y;
  logic             c_cin, c_swap;

  always_comb begin
    c_x    = a;
    c_y    = b;
    c_cin  = 1'b0;
    c_swap = 1'b0;
    case (mode)
      MODE_SUB: begin
        c_y   = ~b;
        c_cin = 1'b1;
      end
      MODE_ABS: begin
        c_cin = 1'b1;
        if (a < b) begin
          c_x    = b;
          c_y    = ~a;
          c_swap = 1'b1;
        end else begin
          c_y = ~b;
        end
      end
      MODE_ACC: begin
        c_x = '0;
        c_y = a;
      end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] op_x, raw_sum, res;
  logic             raw_cout, raw_ovf, flag_c;

  always_comb begin
    op_x = s1_x;
    if (s1_mode == MODE_ACC) op_x = s1_clr ? '0 : acc_q;
    {raw_cout, raw_sum} = prefix_add(op_x, s1_y, s1_cin);
    raw_ovf = (s1_mode != MODE_ABS) && (op_x[WIDTH-1] == s1_y[WIDTH-1]) &&
              (raw_sum[WIDTH-1] != op_x[WIDTH-1]);
    flag_c  = (s1_mode == MODE_ABS) ? s1_swap : raw_cout;
    res     = raw_sum;
`ifdef SKLANSKY_SAT_EN
    if ((s1_mode == MODE_ADD || s1_mode == MODE_ACC) && raw_cout) res = '1;
    else if (s1_mode == MODE_SUB && !raw_cout) res = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_cin    <= 1'b0;
      s1_clr    <= 1'b0;
      s1_swap   <= 1'b0;
      s1_mode   <= MODE_ADD;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc_q     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_x     <= c_x;
        s1_y     <= c_y;
        s1_cin   <= c_cin;
        s1_clr   <= acc_clr;
        s1_swap  <= c_swap;
        s1_mode  <= mode;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // acc_q follows the loaded result so a trailing acc in stage 1 sees it next cycle.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= res;
          cout <= flag_c;
          ovf  <= raw_ovf;
          if (s1_mode == MODE_ACC) acc_q <= res;
        end
      end
    end
  end

endmodule
